calculation_unit_exponent_pipeline: RTL and testbench

Parametrised, pipelined exponent path for the calculation unit. It takes the operation select and two aligned, signed, unbiased exponents and produces the calculated exponent for ADD/SUB/MUL/DIV/SQRT. It adds a square-root odd-exponent flag and optional overflow/underflow range flags. The exponent is carried through a configurable number of register stages under a valid/ready handshake, so it stays aligned with the mantissa datapath. Throughput is one operation per cycle.

---
 rtl/calculation_unit_exponent_pipeline_pkg.sv | 26 ++
 rtl/calculation_unit_exponent_pipeline_compute.sv | 62 ++++++
 rtl/calculation_unit_exponent_pipeline.sv | 99 +++++++++
 tb/tb_calculation_unit_exponent_pipeline.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/calculation_unit_exponent_pipeline_pkg.sv
// Shared types for the calculation unit exponent path: the operation select
// and the payload carried by every exponent pipeline stage.
package calculation;

  // Widest supported input exponent (double precision) and its result width.
  localparam int MAX_EXP_WIDTH = 11;
  localparam int RES_MAX_W     = MAX_EXP_WIDTH + 2;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    MUL  = 3'd2,
    DIV  = 3'd3,
    SQRT = 3'd4
  } calculation_select;

  // Result is held sign-extended to the widest format; narrower
  // configurations use the low EXP_WIDTH+2 bits.
  typedef struct packed {
    logic signed [RES_MAX_W-1:0] result;
    logic                        sqrt_odd;
    logic                        overflow;
    logic                        underflow;
  } exp_stage_t;

endpackage

// File: rtl/calculation_unit_exponent_pipeline_compute.sv
// Combinational exponent arithmetic: operation select, signed add/sub/shift,
// sqrt odd flag and (with CALC_EXP_RANGE_FLAGS_EN) range flags.
module calculation_unit_exponent_compute
  import calculation::*;
#(
  parameter int EXP_WIDTH = 8
) (
  input  calculation::calculation_select op_select,
  input  logic signed [EXP_WIDTH-1:0]    exponent_a,
  input  logic signed [EXP_WIDTH-1:0]    exponent_b,
  output exp_stage_t                     payload
);

  localparam int W2 = EXP_WIDTH + 2;
`ifdef CALC_EXP_RANGE_FLAGS_EN
  localparam logic signed [W2-1:0] EMAX = W2'(2 ** (EXP_WIDTH - 1) - 1);
  localparam logic signed [W2-1:0] EMIN = W2'(-(2 ** (EXP_WIDTH - 1) - 2));

  function automatic logic above_max(input logic signed [W2-1:0] v);
    return v > EMAX;
  endfunction

  function automatic logic below_min(input logic signed [W2-1:0] v);
    return v < EMIN;
  endfunction
`endif

  logic signed [W2-1:0] a_ext;
  logic signed [W2-1:0] b_ext;
  logic signed [W2-1:0] res;
  logic                 odd;

  assign a_ext = W2'(exponent_a);
  assign b_ext = W2'(exponent_b);

  // Operation select; unknown encodings fall back to passing A through.
  always_comb begin
    res = a_ext;
    odd = 1'b0;
    case (op_select)
      MUL:     res = a_ext + b_ext;
      DIV:     res = a_ext - b_ext;
      SQRT: begin
        res = b_ext >>> 1;
        odd = exponent_b[0];
      end
      default: res = a_ext;
    endcase
  end

  // Pack the stage-0 payload.
  always_comb begin
    payload          = '0;
    payload.result   = RES_MAX_W'(res);
    payload.sqrt_odd = odd;
`ifdef CALC_EXP_RANGE_FLAGS_EN
    payload.overflow  = above_max(res);
    payload.underflow = below_min(res);
`endif
  end

endmodule

// File: rtl/calculation_unit_exponent_pipeline.sv
// Pipelined exponent path: a PIPE_DEPTH-deep valid/payload register chain
// with valid/ready handshake around the combinational exponent compute.
// Optional range flags are built when CALC_EXP_RANGE_FLAGS_EN is defined;
// otherwise exponent_overflow/exponent_underflow are constant 0.
module calculation_unit_exponent_pipeline
  import calculation::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  calculation::calculation_select calculation_select,
  input  logic signed [EXP_WIDTH-1:0]    aligned_exponent_a,
  input  logic signed [EXP_WIDTH-1:0]    aligned_exponent_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [EXP_WIDTH+1:0]    calculated_exponent,
  output logic                           sqrt_odd,
  output logic                           exponent_overflow,
  output logic                           exponent_underflow
);

  localparam int LAST = PIPE_DEPTH - 1;

  exp_stage_t comp_p0;
  exp_stage_t stage_p [PIPE_DEPTH];
  logic       vld_p   [PIPE_DEPTH];
  logic       load    [PIPE_DEPTH];
  exp_stage_t src_pay [PIPE_DEPTH];
  logic       src_vld [PIPE_DEPTH];

  calculation_unit_exponent_compute #(
    .EXP_WIDTH (EXP_WIDTH)
  ) u_compute (
    .op_select  (calculation_select),
    .exponent_a (aligned_exponent_a),
    .exponent_b (aligned_exponent_b),
    .payload    (comp_p0)
  );

  // Ready chain: a stage loads when empty or when its contents move on.
  always_comb begin : ready_chain
    logic take;
    take = out_ready;
    for (int i = LAST; i >= 0; i--) begin
      load[i] = !vld_p[i] || take;
      take    = load[i];
    end
  end

  // Source of each stage: compute output for stage 0, previous stage otherwise.
  always_comb begin
    src_vld[0] = in_valid;
    src_pay[0] = comp_p0;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      src_vld[i] = vld_p[i-1];
      src_pay[i] = stage_p[i-1];
    end
  end

  // Stage registers: payload captured only on a transfer, stalled stages hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        vld_p[i]   <= 1'b0;
        stage_p[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        if (load[i]) begin
          vld_p[i] <= src_vld[i];
          if (src_vld[i]) stage_p[i] <= src_pay[i];
        end
      end
    end
  end

  // Full-width view of the last stage result; only the low bits leave the block.
  logic signed [RES_MAX_W-1:0] unused_res_full;
  assign unused_res_full = stage_p[LAST].result;

  assign in_ready            = load[0];
  assign out_valid           = vld_p[LAST];
  assign calculated_exponent = unused_res_full[EXP_WIDTH+1:0];
  assign sqrt_odd            = stage_p[LAST].sqrt_odd;
`ifdef CALC_EXP_RANGE_FLAGS_EN
  assign exponent_overflow   = stage_p[LAST].overflow;
  assign exponent_underflow  = stage_p[LAST].underflow;
`else
  logic unused_flags;
  assign unused_flags        = stage_p[LAST].overflow ^ stage_p[LAST].underflow;
  assign exponent_overflow   = 1'b0;
  assign exponent_underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_calculation_unit_exponent_pipeline.sv
// Directed bench for calculation_unit_exponent_pipeline: single-precision
// configuration (depth 2) and double-precision configuration (depth 4).
module tb_calculation_unit_exponent_pipeline;
  import calculation::*;

`ifdef CALC_EXP_RANGE_FLAGS_EN
  localparam int FLAG = 1;
`else
  localparam int FLAG = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic                iv8, ir8, ov8, or8;
  calculation_select   sel8;
  logic signed [7:0]   a8, b8;
  logic signed [9:0]   ce8;
  logic                odd8, ovf8, unf8;

  logic                iv11, ir11, ov11, or11;
  calculation_select   sel11;
  logic signed [10:0]  a11, b11;
  logic signed [12:0]  ce11;
  logic                odd11, ovf11, unf11;

  calculation_unit_exponent_pipeline #(.EXP_WIDTH(8), .PIPE_DEPTH(2)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .calculation_select(sel8), .aligned_exponent_a(a8), .aligned_exponent_b(b8),
    .out_valid(ov8), .out_ready(or8), .calculated_exponent(ce8),
    .sqrt_odd(odd8), .exponent_overflow(ovf8), .exponent_underflow(unf8)
  );

  calculation_unit_exponent_pipeline #(.EXP_WIDTH(11), .PIPE_DEPTH(4)) dut11 (
    .clk(clk), .reset(reset), .in_valid(iv11), .in_ready(ir11),
    .calculation_select(sel11), .aligned_exponent_a(a11), .aligned_exponent_b(b11),
    .out_valid(ov11), .out_ready(or11), .calculated_exponent(ce11),
    .sqrt_odd(odd11), .exponent_overflow(ovf11), .exponent_underflow(unf11)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input calculation_select s, input int a, input int b);
    sel8 = s;
    a8   = 8'(a);
    b8   = 8'(b);
    iv8  = 1'b1;
    step();
    iv8  = 1'b0;
  endtask

  task automatic expect8(input string tag, input int res, input int odd,
                         input int ovf, input int unf);
    check({tag, "_valid"}, 32'(ov8), 1);
    check({tag, "_res"},   32'(ce8), res);
    check({tag, "_odd"},   32'(odd8), odd);
    check({tag, "_ovf"},   32'(ovf8), ovf);
    check({tag, "_unf"},   32'(unf8), unf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops [6];
    int idx, outidx, gaps, stale;
    logic acc;

    reset = 1'b1;
    iv8 = 1'b0; or8 = 1'b1; sel8 = ADD; a8 = '0; b8 = '0;
    iv11 = 1'b0; or11 = 1'b1; sel11 = ADD; a11 = '0; b11 = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_out_valid8", 32'(ov8), 0);
    check("rst_res8",       32'(ce8), 0);
    check("rst_flags8",     32'({odd8, ovf8, unf8}), 0);
    check("rst_in_ready8",  32'(ir8), 1);
    check("rst_out_valid11", 32'(ov11), 0);
    check("rst_in_ready11",  32'(ir11), 1);

    // Single operations through the depth-2 pipe.
    issue8(MUL, 100, 50);
    check("mul_latency", 32'(ov8), 0);
    step();
    expect8("mul_100_50", 150, 0, FLAG, 0);

    issue8(DIV, -100, 30);  step(); expect8("div_m100_30", -130, 0, 0, FLAG);
    issue8(DIV, 10, -5);    step(); expect8("div_10_m5", 15, 0, 0, 0);
    issue8(SQRT, 5, -3);    step(); expect8("sqrt_m3", -2, 1, 0, 0);
    issue8(SQRT, -1, 8);    step(); expect8("sqrt_8", 4, 0, 0, 0);
    issue8(ADD, -7, 3);     step(); expect8("add_m7", -7, 0, 0, 0);
    issue8(SUB, 20, 99);    step(); expect8("sub_20", 20, 0, 0, 0);
    issue8(calculation_select'(3'd7), 33, 1); step(); expect8("sel7", 33, 0, 0, 0);
    issue8(MUL, 100, 27);   step(); expect8("mul_emax", 127, 0, 0, 0);
    issue8(MUL, 100, 28);   step(); expect8("mul_emax_p1", 128, 0, FLAG, 0);
    issue8(DIV, -100, 26);  step(); expect8("div_emin", -126, 0, 0, 0);
    issue8(DIV, -100, 27);  step(); expect8("div_emin_m1", -127, 0, 0, FLAG);
    step();

    // Back-pressure: stream 6 ops with out_ready low for 4 cycles.
    for (int k = 0; k < 6; k++) ops[k] = 11 + k;
    or8 = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      sel8 = ADD; a8 = 8'(ops[idx]); b8 = 8'(0); iv8 = 1'b1;
      #1;
      acc = ir8;
      step();
      if (acc) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready_low", 32'(ir8), 0);
    check("bp_out_valid", 32'(ov8), 1);

    or8 = 1'b1;
    outidx = 0;
    gaps = 0;
    for (int c = 0; c < 20 && outidx < 6; c++) begin
      if (idx < 6) begin
        iv8 = 1'b1; a8 = 8'(ops[idx]);
      end else begin
        iv8 = 1'b0;
      end
      #1;
      if (c == 0) check("full_drain_in_ready", 32'(ir8), 1);
      acc = iv8 && ir8;
      if (ov8) begin
        check("stream_out", 32'(ce8), ops[outidx]);
        outidx++;
      end else begin
        gaps++;
      end
      step();
      if (acc) idx++;
    end
    iv8 = 1'b0;
    check("stream_count", outidx, 6);
    check("stream_inputs", idx, 6);
    check("stream_gaps", gaps, 0);
    #1;
    check("stream_drained", 32'(ov8), 0);

    // Reset while full and stalled.
    or8 = 1'b0;
    sel8 = SQRT; a8 = 8'(0); b8 = 8'(-3); iv8 = 1'b1;
    step();
    sel8 = MUL; a8 = 8'(100); b8 = 8'(50);
    step();
    iv8 = 1'b0;
    #1;
    check("stall_full_in_ready", 32'(ir8), 0);
    check("stall_full_out_valid", 32'(ov8), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst2_out_valid", 32'(ov8), 0);
    check("rst2_res", 32'(ce8), 0);
    check("rst2_odd", 32'(odd8), 0);
    check("rst2_ovf", 32'(ovf8), 0);
    check("rst2_unf", 32'(unf8), 0);
    check("rst2_in_ready", 32'(ir8), 1);
    or8 = 1'b1;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ov8) stale++;
    end
    check("rst2_no_stale", stale, 0);

    // Double precision, depth 4.
    sel11 = MUL; a11 = 11'(1000); b11 = 11'(100); iv11 = 1'b1;
    step();
    iv11 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("d11_latency", 32'(ov11), 0);
      step();
    end
    check("d11_valid", 32'(ov11), 1);
    check("d11_res",   32'(ce11), 1100);
    check("d11_ovf",   32'(ovf11), FLAG);
    check("d11_unf",   32'(unf11), 0);
    check("d11_odd",   32'(odd11), 0);
    step();
    check("d11_drained", 32'(ov11), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
